// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- execute-stage ALU with iterative signed multiply/divide.
//
// Single-cycle logic, arithmetic, shift and compare operations produce
// Result combinationally.  Signed multiply (0101) and divide (1011) run a
// bit-serial shift-add / restoring shift-subtract loop of WIDTH steps and
// write HI/LO, holding Busy high so the hazard unit stalls IF/ID/EX.
//
// Optional feature macro: MUL_EARLY_TERM_EN
//   defined   - multiply finishes once the remaining multiplier bits are zero
//   undefined - every multiply takes exactly WIDTH iterations
//
// Ports:
//   Clk          rising-edge clock
//   Reset        synchronous, active-high reset
//   Start        EX stage holds a valid instruction
//   ALU_Control  4-bit operation code
//   A, B         operands (rs, rt/immediate)
//   Shamt        shift amount
//   Result       single-cycle result (combinational)
//   Zero         Result == 0 (combinational)
//   Busy         stall request (combinational)
//   Done         one-cycle pulse when HI/LO are updated
//   HI, LO       multiply high/low word, divide remainder/quotient
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Shamt,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_MULT = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v);
    // INT_MIN maps to itself, which is its correct unsigned magnitude.
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] sign_fix_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] sign_fix_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic signed [WIDTH-1:0] a_s, b_s;
  assign a_s = A;
  assign b_s = B;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mc_q, mc_d;     // multiplicand, shifted left each step
  logic [WIDTH-1:0]     b_q, b_d;       // multiplier (shifted right) or divisor
  logic [2*WIDTH-1:0]   acc_q, acc_d;   // product, or {remainder, dividend/quotient}
  logic                 neg_q, neg_d;   // operand signs differ
  logic                 sa_q, sa_d;     // sign of A (remainder sign)
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 is_long, issue, mul_last;
  logic [WIDTH:0]       rem_sh, diff;

  // Single-cycle datapath
  always_comb begin
    Result = '0;
    unique case (ALU_Control)
      OP_AND:  Result = A & B;
      OP_OR:   Result = A | B;
      OP_ADD:  Result = A + B;
      OP_SUB:  Result = A - B;
      OP_XOR:  Result = A ^ B;
      OP_NOR:  Result = ~(A | B);
      OP_SLT:  Result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLL:  Result = B << Shamt;
      OP_SRL:  Result = B >> Shamt;
      OP_SRA:  Result = b_s >>> Shamt;
      default: Result = '0;
    endcase
  end

  assign Zero    = (Result == '0);
  assign is_long = (ALU_Control == OP_MULT) || (ALU_Control == OP_DIV);
  assign issue   = (state_q == S_IDLE) && Start && is_long;
  assign Busy    = issue || (state_q == S_MUL) || (state_q == S_DIV);
  assign Done    = (state_q == S_DONE);
  assign HI      = hi_q;
  assign LO      = lo_q;

`ifdef MUL_EARLY_TERM_EN
  // Stop once the multiplier has no set bits left after this step's shift.
  assign mul_last = (b_q[WIDTH-1:1] == '0);
`else
  assign mul_last = (cnt_q == CW'(WIDTH-1));
`endif

  // Restoring divide step: bring down the next dividend bit and trial-subtract.
  assign rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff   = rem_sh - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_d    = mc_q;
    b_d     = b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          cnt_d = '0;
          b_d   = abs_w(b_s);
          neg_d = A[WIDTH-1] ^ B[WIDTH-1];
          sa_d  = A[WIDTH-1];
          if (ALU_Control == OP_MULT) begin
            state_d = S_MUL;
            mc_d    = {{WIDTH{1'b0}}, abs_w(a_s)};
            acc_d   = '0;
          end else begin
            state_d = S_DIV;
            mc_d    = '0;
            acc_d   = {{WIDTH{1'b0}}, abs_w(a_s)};
          end
        end
      end
      S_MUL: begin
        if (b_q[0]) acc_d = acc_q + mc_q;
        mc_d  = mc_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (mul_last) begin
          {hi_d, lo_d} = sign_fix_2w(acc_d, neg_q);
          cnt_d        = '0;
          state_d      = S_DONE;
        end
      end
      S_DIV: begin
        if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          // Divide by zero yields an all-ones quotient; remainder is A.
          lo_d    = (b_q == '0) ? '1 : sign_fix_w(acc_d[WIDTH-1:0], neg_q);
          hi_d    = sign_fix_w(acc_d[2*WIDTH-1:WIDTH], sa_q);
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mc_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_q    <= mc_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int W = 32;
`ifdef MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic [3:0]   ALU_Control = 4'b0000;
  logic [W-1:0] A = '0, B = '0;
  logic [4:0]   Shamt = '0;
  logic [W-1:0] Result, HI, LO;
  logic         Zero, Busy, Done;

  alu_exec_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ALU_Control(ALU_Control),
    .A(A), .B(B), .Shamt(Shamt), .Result(Result), .Zero(Zero),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [W-1:0] res; logic zero; } cexp_t;
  typedef struct { logic [W-1:0] hi; logic [W-1:0] lo; int cyc; } lexp_t;
  cexp_t cq[$];
  lexp_t lq[$];
  bit    comb_req = 1'b0;

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge Clk) begin
    if (comb_req) begin
      cexp_t e;
      comb_req = 1'b0;
      if (cq.size() == 0) begin
        check("comb_queue_empty", 64'd1, 64'd0);
      end else begin
        e = cq.pop_front();
        check("result", {32'd0, Result}, {32'd0, e.res});
        check("zero", {63'd0, Zero}, {63'd0, e.zero});
        check("busy_single", {63'd0, Busy}, 64'd0);
      end
    end
    if (!Reset && Done) begin
      lexp_t e;
      if (lq.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = lq.pop_front();
        check("hi", {32'd0, HI}, {32'd0, e.hi});
        check("lo", {32'd0, LO}, {32'd0, e.lo});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic comb_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] sh, input logic [W-1:0] exp_res);
    @(posedge Clk); #1;
    Start = 1'b0; ALU_Control = op; A = a; B = b; Shamt = sh;
    cq.push_back('{res: exp_res, zero: (exp_res == '0)});
    comb_req = 1'b1;
  endtask

  // Issue a long op with Start held until Busy falls; returns in the DONE cycle.
  task automatic long_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input int lat);
    int bc;
    bit fell;
    @(posedge Clk); #1;
    Start = 1'b1; ALU_Control = op; A = a; B = b;
    lq.push_back('{hi: exp_hi, lo: exp_lo, cyc: cyc + lat});
    bc = 0; fell = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge Clk);
      if (!Busy) begin fell = 1'b1; break; end
      bc++;
    end
    check("busy_fell", {63'd0, fell}, 64'd1);
    check("busy_cycles", 64'(bc), 64'(lat));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
    end
  endtask

  initial begin
    int t0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("rst_hi", {32'd0, HI}, 64'd0);
    check("rst_lo", {32'd0, LO}, 64'd0);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);

    comb_op(4'b0010, 32'd5, 32'd7, 5'd0, 32'd12);
    comb_op(4'b0110, 32'd9, 32'd9, 5'd0, 32'd0);
    comb_op(4'b0110, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE);
    comb_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);
    comb_op(4'b1010, 32'd0, 32'hF000_0000, 5'd4, 32'hFF00_0000);
    comb_op(4'b1001, 32'd0, 32'hF000_0000, 5'd4, 32'h0F00_0000);
    comb_op(4'b1000, 32'd0, 32'd1, 5'd31, 32'h8000_0000);
    comb_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
    comb_op(4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0);
    comb_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000);
    comb_op(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0);
    comb_op(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0);
    comb_op(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h000F_000F);
    comb_op(4'b1111, 32'd5, 32'd7, 5'd3, 32'd0);
    comb_op(4'b0101, 32'd5, 32'd7, 5'd0, 32'd0);

    long_op(4'b0101, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, ET ? 4 : 33);
    idle(2);

    // Back-to-back divides, each issued the cycle after the previous DONE.
    long_op(4'b1011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    long_op(4'b1011, 32'd10, 32'd0, 32'h0000_000A, 32'hFFFF_FFFF, 33);
    long_op(4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    idle(1);

    long_op(4'b0101, 32'd5, 32'd1, 32'd0, 32'd5, ET ? 2 : 33);
    long_op(4'b0101, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 33);
    idle(2);

    // Reset during a divide: no completion is expected for it.
    @(posedge Clk); #1;
    Start = 1'b1; ALU_Control = 4'b1011; A = 32'd100; B = 32'd3;
    t0 = cyc;
    @(posedge Clk); #1;
    Start = 1'b0;
    while (cyc < t0 + 10) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    @(negedge Clk);
    check("busy_before_reset", {63'd0, Busy}, 64'd1);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("mid_rst_busy", {63'd0, Busy}, 64'd0);
    check("mid_rst_done", {63'd0, Done}, 64'd0);
    check("mid_rst_hi", {32'd0, HI}, 64'd0);
    check("mid_rst_lo", {32'd0, LO}, 64'd0);

    long_op(4'b0101, 32'd6, 32'd7, 32'd0, 32'd42, ET ? 4 : 33);
    idle(5);

    check("pending_done", 64'(lq.size()), 64'd0);
    check("pending_comb", 64'(cq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage datapath that consumes the 4-bit ALU_Control code from the ALU control decoder.
- Performs single-cycle logic, arithmetic, shift and compare ops combinationally.
- Performs iterative signed multiply and divide into HI/LO over WIDTH cycles, asserting Busy so the hazard unit stalls IF/ID/EX.

Parameters:
WIDTH, 32, datapath width; also the multiply/divide iteration count.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Start  input  1  EX stage holds a valid instruction
ALU_Control  input  4  operation code from the ALU control decoder
A  input  WIDTH  operand rs
B  input  WIDTH  operand rt or immediate
Shamt  input  5  shift amount
Result  output  WIDTH  single-cycle result, combinational
Zero  output  1  Result == 0, combinational
Busy  output  1  stall request, combinational
Done  output  1  one-cycle pulse when HI/LO are updated
HI  output  WIDTH  multiply high word / divide remainder
LO  output  WIDTH  multiply low word / divide quotient

Behaviour:
- Single-cycle codes (Result valid in the same cycle, regardless of Start):
  - 0000 A&B; 0001 A|B; 0010 A+B (wrapping, no trap); 0110 A-B; 0100 A^B; 1100 ~(A|B).
  - 0111 signed A<B → 1, else 0.
  - 1000 B<<Shamt; 1001 B>>Shamt logical; 1010 B>>>Shamt arithmetic.
  - Any other code: Result=0.
- Long codes: 0101 mult (signed), 1011 div (signed). Result=0 for both.
- States: IDLE, MUL, DIV, DONE. Counter runs 0..WIDTH-1.
- IDLE: Start=1 with a long code is the issue cycle t.
  - Busy=1 combinationally during t.
  - At end of t: |A| and |B| latched, signs recorded, counter=0, go to MUL/DIV.
- MUL/DIV, cycles t+1..t+WIDTH:
  - One shift-add (MUL) or restoring shift-subtract (DIV) step per cycle; Busy=1.
  - At end of last iteration, sign-corrected results written to HI/LO; go to DONE.
- Sign correction:
  - mult: product negated if the operand signs differ.
  - div: quotient negated if the signs differ; remainder takes the sign of A.
- DONE, cycle t+WIDTH+1: Done=1, Busy=0, go to IDLE. Start is ignored in DONE; it is the same stalled instruction.
- Total Busy duration = WIDTH+1 cycles. Start is ignored while in MUL/DIV.
- Divide by zero: full latency; LO=all ones, HI=A.
- INT_MIN/-1: LO=INT_MIN, HI=0.
- HI/LO hold their value except at the DONE transition.
- Reset, including mid-operation: state=IDLE, counter=0, HI=LO=0, Done=0, internal operand registers cleared. Busy=0 in the cycle after Reset unless a new issue occurs.
- A long op issued in the cycle immediately after DONE starts normally (back-to-back).

Optional Feature:
MUL_EARLY_TERM_EN
- Defined:
  - MUL leaves for DONE at the end of the iteration in which the remaining shifted multiplier becomes zero (minimum 1 iteration).
  - Busy lasts iterations+1 cycles. DIV is unchanged.
- Undefined: every mult takes exactly WIDTH iterations.

Test Plan:
- add A=5,B=7 → Result=12, Zero=0, Busy=0; sub A=9,B=9 → Result=0, Zero=1.
- sra B=0xF0000000,Shamt=4 → 0xFF000000; slt A=0xFFFFFFFF,B=1 → Result=1; code 1111 → Result=0.
- mult A=-3,B=7, Start held until Busy falls:
  - Busy=1 for 33 cycles, Done at t+33.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB; exactly one Done pulse.
- div A=-7,B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; div A=10,B=0 → LO=0xFFFFFFFF, HI=0x0000000A.
- Reset pulsed at t+10 of a div → next cycle Busy=0, Done=0, HI=LO=0; subsequent mult 6×7 → LO=42, HI=0.
- With MUL_EARLY_TERM_EN, mult A=5,B=1 → Done at t+2; without it → Done at t+33.
